// File: rtl/sorted_array_writer.sv
// Inserts one value per request into a single-port synchronous RAM, keeping
// entries 0..count-1 ascending via a top-down shift-up scan.
module sorted_array_writer #(
    parameter int data_width = 8,
    parameter int addr_width = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [data_width-1:0] value,
    input  logic [data_width-1:0] mem_rdata,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  rejected,
    output logic [addr_width:0]   count
);

    localparam int DEPTH = 1 << addr_width;
    localparam logic [addr_width:0] FULL = (addr_width + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_PLACE,
        S_REJECT,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [data_width-1:0] val;
    logic [addr_width:0]   idx, idx_nxt, idx_m1;
    logic                  we_c;
    logic                  accept;

    assign idx_m1 = idx - 1'b1;
    assign accept = (state == S_IDLE) && !clear && start;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        we_c      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    idx_nxt = count;
                    if (count == FULL)
                        state_nxt = S_REJECT;
                    else if (count == '0)
                        state_nxt = S_PLACE;
                    else
                        state_nxt = S_READ;
                end
            end
            S_READ: begin
                mem_addr  = idx_m1[addr_width-1:0];
                state_nxt = S_CMP;
            end
            S_CMP: begin
                // Strict compare so a new value settles above its equals.
                if (mem_rdata > val) begin
                    we_c      = 1'b1;
                    mem_addr  = idx[addr_width-1:0];
                    mem_wdata = mem_rdata;
                    idx_nxt   = idx_m1;
                    state_nxt = (idx_m1 == '0) ? S_PLACE : S_READ;
                end else begin
                    state_nxt = S_PLACE;
                end
            end
            S_PLACE: begin
                we_c      = 1'b1;
                mem_addr  = idx[addr_width-1:0];
                mem_wdata = val;
                state_nxt = S_DONE;
            end
            S_REJECT: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Suppress the write on a reset edge so an aborted shift leaves no extra store.
    assign mem_we = we_c & reset;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            count    <= '0;
            rejected <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == S_IDLE && clear)
                count <= '0;
            else if (state == S_PLACE)
                count <= count + 1'b1;
            if (state == S_REJECT)
                rejected <= 1'b1;
            else if (state == S_DONE)
                rejected <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            val <= value;
    end

endmodule

// File: tb/tb_sorted_array_writer.sv
// Self-checking bench: behavioural RAM, reference sorted-array model and a
// scoreboard queue of expected {count, rejected, latency} per request.
module tb_sorted_array_writer;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] value = '0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          rejected;
    logic [AW:0]   count;

    sorted_array_writer #(.data_width(DW), .addr_width(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .value(value),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .busy(busy), .done(done), .rejected(rejected),
        .count(count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];
    int log_a[$];
    int log_d[$];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            log_a.push_back(int'(mem_addr));
            log_d.push_back(int'(mem_wdata));
        end else begin
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        int count;
        int rej;
        int lat;
    } exp_t;

    typedef struct {
        logic [DW-1:0] value;
        int            exp_count;
        int            exp_rej;
        int            exp_lat;
    } vec_t;

    exp_t sb[$];
    int   ref_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference insertion; returns the expected outcome of the request.
    task automatic model_ins(input int v, output int ec, output int er, output int el);
        int n, pos, k, e;
        n = ref_q.size();
        if (n == DEPTH) begin
            ec = n; er = 1; el = 2;
            return;
        end
        pos = n;
        for (int i = 0; i < n; i++) begin
            if (ref_q[i] > v) begin
                pos = i;
                break;
            end
        end
        k = n - pos;
        e = (k < n) ? k + 1 : n;
        ref_q.insert(pos, v);
        ec = n + 1; er = 0; el = 2 * e + 2;
    endtask

    task automatic do_insert(input int v, input int ec, input int er, input int el);
        exp_t e;
        int   cyc;
        e.count = ec; e.rej = er; e.lat = el;
        sb.push_back(e);
        value = DW'(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        if (!done) chk("done_timeout", 0, 1);
        chk("latency", cyc, e.lat);
        chk("rejected", int'(rejected), e.rej);
        chk("count_at_done", int'(count), e.count);
        @(posedge clk); #1;
    endtask

    task automatic ins(input int v);
        int ec, er, el;
        model_ins(v, ec, er, el);
        do_insert(v, ec, er, el);
    endtask

    task automatic check_ram(input string name);
        for (int i = 0; i < ref_q.size(); i++)
            chk(name, int'(ram[i]), ref_q[i]);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        ref_q.delete();
        chk("clear_count", int'(count), 0);
        chk("clear_no_done", int'(done), 0);
    endtask

    task automatic check_log(input string name, input int a[$], input int d[$]);
        chk({name, "_nwrites"}, log_a.size(), a.size());
        if (log_a.size() == a.size()) begin
            for (int i = 0; i < a.size(); i++) begin
                chk({name, "_addr"}, log_a[i], a[i]);
                chk({name, "_data"}, log_d[i], d[i]);
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        int ec, er, el, cyc;
        int ea[$];
        int ed[$];

        vecs[0] = '{8'd30, 1, 0, 2};
        vecs[1] = '{8'd10, 2, 0, 4};
        vecs[2] = '{8'd20, 3, 0, 6};
        vecs[3] = '{8'd15, 4, 0, 8};
        vecs[4] = '{8'd40, 5, 0, 4};
        vecs[5] = '{8'd20, 6, 0, 8};
        vecs[6] = '{8'd5,  7, 0, 14};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rejected", int'(rejected), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_we", int'(mem_we), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Empty insert
        log_a.delete(); log_d.delete();
        ins(42);
        ea = '{0}; ed = '{42};
        check_log("empty", ea, ed);
        do_clear();

        // Table-driven sequence of inserts from empty
        for (int i = 0; i < 7; i++) begin
            model_ins(int'(vecs[i].value), ec, er, el);
            do_insert(int'(vecs[i].value), vecs[i].exp_count, vecs[i].exp_rej, vecs[i].exp_lat);
        end
        check_ram("table_ram");
        do_clear();

        // Middle insert: shift order
        ins(10); ins(20); ins(30);
        log_a.delete(); log_d.delete();
        ins(15);
        ea = '{3, 2, 1}; ed = '{30, 20, 15};
        check_log("middle", ea, ed);
        check_ram("middle_ram");
        do_clear();

        // Smallest value
        ins(5); ins(6);
        ins(1);
        check_ram("smallest_ram");
        do_clear();

        // Duplicate lands above existing equal
        ins(10); ins(20);
        log_a.delete(); log_d.delete();
        ins(20);
        ea = '{2}; ed = '{20};
        check_log("dup", ea, ed);
        do_clear();

        // Fill to full, then reject
        for (int i = 0; i < DEPTH; i++)
            ins(int'($urandom_range(0, 255)));
        check_ram("full_ram");
        log_a.delete(); log_d.delete();
        ins(7);
        chk("reject_nwrites", log_a.size(), 0);
        chk("full_count", int'(count), DEPTH);
        do_clear();
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_clear_done", int'(done), 0);
        end

        // Reset during a CMP shift
        ins(10); ins(20); ins(30);
        value = 8'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!mem_we && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midop_saw_shift", int'(mem_we), 1);
        reset = 1'b0;
        #1;
        chk("midop_we_in_reset", int'(mem_we), 0);
        @(posedge clk); #1;
        chk("midop_busy", int'(busy), 0);
        chk("midop_count", int'(count), 0);
        chk("midop_we", int'(mem_we), 0);
        chk("midop_done", int'(done), 0);
        reset = 1'b1;
        ref_q.delete();

        // Start/clear while busy are ignored
        log_a.delete(); log_d.delete();
        value = 8'd50;
        start = 1'b1;
        @(posedge clk); #1;
        value = 8'd99;
        clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
        chk("busy_ign_done", int'(done), 1);
        chk("busy_ign_count", int'(count), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_ign_idle", int'(busy), 0);
        chk("busy_ign_count2", int'(count), 1);
        ea = '{0}; ed = '{50};
        check_log("busy_ign", ea, ed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sorted_array_writer.md
# sorted_array_writer

Write-side companion to the binary-search engine. It inserts one value per request into a single-port synchronous RAM while keeping entries 0..count-1 in ascending order, so the searcher can read the same RAM afterwards. Insertion is a top-down scan that shifts larger entries up one slot, then writes the new value into the gap. The block owns the RAM port while busy and reports the current fill level.

## Interface

- data_width, 8: width of stored values and of `value`.
- addr_width, 5: RAM address width; capacity DEPTH = 2**addr_width entries.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low (asserted when 0); the clock and reset are named clk and reset as elsewhere in the codebase.
- start  in  1  insert request; sampled only in IDLE.
- clear  in  1  empty the array (count := 0); sampled only in IDLE; has priority over start.
- value  in  data_width  value to insert; latched on the accepting edge.
- mem_rdata  in  data_width  RAM read data, valid one cycle after mem_addr is presented with mem_we=0.
- mem_addr  out  addr_width  RAM address.
- mem_wdata  out  data_width  RAM write data.
- mem_we  out  1  RAM write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of each accepted request.
- rejected  out  1  valid with done; 1 means the array was full and nothing was written.
- count  out  addr_width+1  number of valid entries, 0..DEPTH.

## Operation

- Internal registers: val (data_width), idx (addr_width+1), state.
- IDLE:
  - clear=1: count := 0; stay in IDLE; no done pulse.
  - Else start=1: val := value; idx := count. Next state is REJECT if count==DEPTH, PLACE if count==0, otherwise READ.
- READ: mem_addr = idx-1, mem_we=0. Next state is CMP.
- CMP (mem_rdata holds mem[idx-1]):
  - mem_rdata > val (strict): mem_we=1, mem_addr=idx, mem_wdata=mem_rdata; idx := idx-1. Next state is PLACE if the new idx is 0, otherwise READ.
  - Else: no write; next state is PLACE.
- PLACE: mem_we=1, mem_addr=idx, mem_wdata=val; count := count+1. Next state is DONE.
- REJECT: no write; rejected := 1. Next state is DONE.
- DONE: done=1 for this cycle only; rejected holds its value (0 unless the request came through REJECT). Next state is IDLE, where rejected clears to 0.
- Equal values: the new value lands above existing equal entries, so insertion order among duplicates is preserved.
- mem_we=0 in IDLE, READ, REJECT, DONE and during reset.
- mem_addr and mem_wdata are combinational from state, idx, val and mem_rdata. In IDLE they are don't-care; drive 0.
- Only entries 0..count-1 are defined. Slots at count and above are never read.

## Timing

- Reset (reset=0 at a rising edge): state=IDLE, count=0, idx=0, done=0, rejected=0, busy=0, mem_we=0.
- Reset mid-operation aborts immediately. The RAM may hold a partial shift, but count=0 makes the array logically empty.
- Request latency: let E be the number of entries examined, E = k+1 if k<n shifts occur, E = n if every entry shifts.
  - Cycles from the accepting edge to the done cycle inclusive = 2E + 2.
  - count==0 gives 2 cycles (PLACE, DONE). A full array gives 2 cycles (REJECT, DONE).
- count updates on the edge leaving PLACE, so it is already incremented while done=1.
- start and clear are ignored while busy=1. A new start may be accepted in the cycle right after DONE.
- No RAM access overlaps another: at most one read or one write per cycle.

## Test plan

- Empty insert: reset, start value=42 -> PLACE writes mem[0]=42; done in 2nd cycle; count=1; rejected=0.
- Middle insert: array [10,20,30], count=3, start 15 -> writes mem[3]=30, mem[2]=20, mem[1]=15 in order; done in 8th cycle; count=4; final [10,15,20,30].
- Smallest value: array [5,6], start 1 -> two shifts then mem[0]=1; done in 6th cycle; final [1,5,6].
- Duplicate: array [10,20], start 20 -> no shift, writes mem[2]=20; done in 4th cycle; count=3.
- Full array: fill to count=32, start 7 -> no mem_we pulse; done and rejected=1 in 2nd cycle; count stays 32. Then clear -> count=0, no done pulse.
- Reset mid-op: assert reset=0 during a CMP shift -> next cycle state=IDLE, busy=0, count=0, mem_we=0. A start ignored while busy writes nothing and leaves count unchanged.
